// File: rtl/sl_rx_pkg.sv
// Shared types and line codes for the clocked SL receiver.
package sl_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLow0,
    StLow1,
    StGap,
    StStopWait,
    StErrWait
  } sl_rx_state_e;

  // Filtered line pair, coded as {f0, f1}
  localparam logic [1:0] SL_IDLE = 2'b11;
  localparam logic [1:0] SL_BIT0 = 2'b01;
  localparam logic [1:0] SL_BIT1 = 2'b10;
  localparam logic [1:0] SL_STOP = 2'b00;

  typedef struct packed {
    logic parity_ok;
    logic len_err;
    logic frame_err;
    logic tout_err;
  } sl_rx_status_t;

endpackage

// File: rtl/sl_line_filter.sv
// Two-flop synchroniser followed by a debounce that needs FILTER_LEN equal samples to move.
module sl_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line};
      // cnt_q holds how many consecutive samples already disagree with level_q
      if (sync_q[1] != level_q) begin
        if (cnt_q == CW'(FILTER_LEN - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/sl_rx_sync.sv
// Clocked SL receiver: conditions both lines, decodes words, flags parity/length/frame/timeout.
// Define SL_RX_STATS_EN to build the good/error word counters.
module sl_rx_sync
  import sl_rx_pkg::*;
#(
  parameter int unsigned MAX_BITS       = 32,
  parameter int unsigned FILTER_LEN     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sl0,
  input  logic                          sl1,
  output logic                          word_busy,
  output logic                          word_valid,
  output logic [MAX_BITS-1:0]           data_out,
  output logic [$clog2(MAX_BITS+2)-1:0] bit_count,
  output logic                          parity_ok,
  output logic                          len_err,
  output logic                          frame_err,
  output logic                          tout_err,
  output logic [15:0]                   good_cnt,
  output logic [15:0]                   err_cnt
);

  localparam int unsigned BW   = $clog2(MAX_BITS + 2);
  localparam int unsigned NW   = $clog2(MAX_BITS + 3);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned NMAX = MAX_BITS + 2;

  logic f0, f1;
  logic [1:0] code;

  sl_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (sl0),
    .level (f0)
  );

  sl_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (sl1),
    .level (f1)
  );

  assign code = {f0, f1};

  sl_rx_state_e    state_q;
  logic [MAX_BITS-1:0] shreg_q, shreg_shift;
  logic [NW-1:0]   n_q, n_inc;
  logic            par_q;
  logic [TW-1:0]   tcnt_q;
  logic            word_busy_q, word_valid_q;
  logic [MAX_BITS-1:0] data_q, term_data;
  logic [BW-1:0]   bcnt_q, term_bcnt;
  sl_rx_status_t   status_q, term_status;

  logic in_bit, is_bit, hold, term, term_frame, term_tout, long_word;
  sl_rx_state_e bit_state;

  assign in_bit    = (code == SL_BIT1);
  assign is_bit    = (code == SL_BIT0) || (code == SL_BIT1);
  assign bit_state = in_bit ? StLow1 : StLow0;
  assign hold      = ((state_q == StLow0) && (code == SL_BIT0)) ||
                     ((state_q == StLow1) && (code == SL_BIT1)) ||
                     ((state_q == StGap)  && (code == SL_IDLE));

  // Bits past MAX_BITS are only counted; the parity bit never needs storing past that point
  always_comb begin
    shreg_shift = shreg_q;
    for (int i = 0; i < int'(MAX_BITS); i++) begin
      if (i == int'(n_q)) shreg_shift[i] = in_bit;
    end
    n_inc = (n_q == NW'(NMAX)) ? n_q : n_q + 1'b1;
  end

  always_comb begin
    term       = 1'b0;
    term_frame = 1'b0;
    term_tout  = 1'b0;
    if ((state_q == StLow0) || (state_q == StLow1) || (state_q == StGap)) begin
      if (code == SL_STOP) begin
        term       = 1'b1;
        term_frame = (state_q != StGap);
      end else if (hold && (tcnt_q == TW'(TIMEOUT_CYCLES - 1))) begin
        term      = 1'b1;
        term_tout = 1'b1;
      end
    end
  end

  always_comb begin
    long_word             = (n_q > NW'(MAX_BITS + 1));
    term_status           = '0;
    term_status.len_err   = (n_q < NW'(2)) || long_word;
    term_status.parity_ok = par_q && !term_status.len_err;
    term_status.frame_err = term_frame;
    term_status.tout_err  = term_tout;
    if (long_word)          term_bcnt = BW'(MAX_BITS);
    else if (n_q == '0)     term_bcnt = '0;
    else                    term_bcnt = BW'(n_q - 1'b1);
    // The last received bit is parity, so only the first n-1 bits are data
    for (int i = 0; i < int'(MAX_BITS); i++) begin
      term_data[i] = shreg_q[i] && ((i + 1) < int'(n_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      n_q          <= '0;
      par_q        <= 1'b0;
      tcnt_q       <= '0;
      word_busy_q  <= 1'b0;
      word_valid_q <= 1'b0;
      data_q       <= '0;
      bcnt_q       <= '0;
      status_q     <= '0;
    end else begin
      word_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tcnt_q <= '0;
          if (is_bit) begin
            state_q     <= bit_state;
            shreg_q     <= MAX_BITS'(in_bit);
            n_q         <= NW'(1);
            par_q       <= in_bit;
            word_busy_q <= 1'b1;
          end else if (code == SL_STOP) begin
            state_q <= StErrWait;
          end
        end
        StLow0, StLow1, StGap: begin
          if (term) begin
            state_q      <= term_status.frame_err || term_status.tout_err ? StErrWait
                                                                          : StStopWait;
            word_valid_q <= 1'b1;
            word_busy_q  <= 1'b0;
            data_q       <= term_data;
            bcnt_q       <= term_bcnt;
            status_q     <= term_status;
            tcnt_q       <= '0;
          end else if (hold) begin
            tcnt_q <= tcnt_q + 1'b1;
          end else begin
            tcnt_q <= '0;
            if (is_bit) begin
              state_q <= bit_state;
              shreg_q <= shreg_shift;
              n_q     <= n_inc;
              par_q   <= par_q ^ in_bit;
            end else begin
              state_q <= StGap;
            end
          end
        end
        StStopWait, StErrWait: begin
          if (code == SL_IDLE) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign word_busy  = word_busy_q;
  assign word_valid = word_valid_q;
  assign data_out   = data_q;
  assign bit_count  = bcnt_q;
  assign parity_ok  = status_q.parity_ok;
  assign len_err    = status_q.len_err;
  assign frame_err  = status_q.frame_err;
  assign tout_err   = status_q.tout_err;

`ifdef SL_RX_STATS_EN
  logic [15:0] good_q, err_q;
  logic        good_word;

  assign good_word = term_status.parity_ok && !term_status.frame_err && !term_status.tout_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q <= '0;
      err_q  <= '0;
    end else if (term) begin
      if (good_word) begin
        if (good_q != 16'hFFFF) good_q <= good_q + 1'b1;
      end else begin
        if (err_q != 16'hFFFF) err_q <= err_q + 1'b1;
      end
    end
  end

  assign good_cnt = good_q;
  assign err_cnt  = err_q;
`else
  assign good_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_sl_rx_sync.sv
// Directed vector bench for sl_rx_sync: table of words plus reset/frame/idle-stop sequences.
module tb_sl_rx_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sl0 = 1'b1;
  logic        sl1 = 1'b1;
  logic        word_busy, word_valid, parity_ok, len_err, frame_err, tout_err;
  logic [31:0] data_out;
  logic [5:0]  bit_count;
  logic [15:0] good_cnt, err_cnt;

  always #5 clk = ~clk;

  sl_rx_sync dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sl0        (sl0),
    .sl1        (sl1),
    .word_busy  (word_busy),
    .word_valid (word_valid),
    .data_out   (data_out),
    .bit_count  (bit_count),
    .parity_ok  (parity_ok),
    .len_err    (len_err),
    .frame_err  (frame_err),
    .tout_err   (tout_err),
    .good_cnt   (good_cnt),
    .err_cnt    (err_cnt)
  );

  typedef struct {
    logic [63:0] bits;
    int          n;
    bit          glitch;
    bit          tout;
    logic [31:0] exp_data;
    int          exp_bcnt;
    bit          exp_par;
    bit          exp_len;
    bit          exp_tout;
  } vec_t;

  int total = 0;
  int bad = 0;
  int exp_good = 0;
  int exp_err = 0;

  int          valid_cnt = 0;
  int          dbl_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] cap_data = '0;
  logic [5:0]  cap_bcnt = '0;
  logic        cap_par = 1'b0, cap_len = 1'b0, cap_frame = 1'b0, cap_tout = 1'b0;
  logic        cap_busy = 1'b0;

  always @(negedge clk) begin
    if (word_valid) begin
      valid_cnt <= valid_cnt + 1;
      cap_data  <= data_out;
      cap_bcnt  <= bit_count;
      cap_par   <= parity_ok;
      cap_len   <= len_err;
      cap_frame <= frame_err;
      cap_tout  <= tout_err;
      cap_busy  <= word_busy;
      if (prev_valid) dbl_cnt <= dbl_cnt + 1;
    end
    prev_valid <= word_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    if (b) sl1 = 1'b0;
    else   sl0 = 1'b0;
    repeat (8) @(negedge clk);
    sl0 = 1'b1;
    sl1 = 1'b1;
    if (glitch) begin
      repeat (3) @(negedge clk);
      sl1 = 1'b0;
      repeat (2) @(negedge clk);
      sl1 = 1'b1;
      repeat (3) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send_stop();
    @(negedge clk);
    sl0 = 1'b0;
    sl1 = 1'b0;
    repeat (8) @(negedge clk);
    sl0 = 1'b1;
    sl1 = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_valid(input int start, input int budget, input string name);
    int i = 0;
    while (valid_cnt == start && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({name, " valid"}, 32'(valid_cnt - start), 32'd1);
  endtask

  task automatic check_word(input string name, input logic [31:0] d, input int bc,
                            input bit p, input bit l, input bit f, input bit t);
    check({name, " data"},  cap_data,  d);
    check({name, " bcnt"},  32'(cap_bcnt), 32'(bc));
    check({name, " par"},   32'(cap_par),  32'(p));
    check({name, " len"},   32'(cap_len),  32'(l));
    check({name, " frame"}, 32'(cap_frame), 32'(f));
    check({name, " tout"},  32'(cap_tout), 32'(t));
    check({name, " busy"},  32'(cap_busy), 32'd0);
    if (p && !f && !t) exp_good++;
    else               exp_err++;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int start = valid_cnt;
    for (int i = 0; i < v.n; i++) begin
      send_bit(v.bits[i], v.glitch && (i == 3));
      if (i == 0) check({name, " open"}, 32'(word_busy), 32'd1);
    end
    if (!v.tout) send_stop();
    wait_valid(start, v.tout ? 1300 : 40, name);
    repeat (4) @(negedge clk);
    check_word(name, v.exp_data, v.exp_bcnt, v.exp_par, v.exp_len, 1'b0, v.exp_tout);
  endtask

  vec_t vecs[8];

  initial begin
    int start;
    vec_t v3c;

    //            bits                  n   gl  to  data           bcnt par len tout
    vecs[0] = '{64'h1A5,                9,  0,  0,  32'h0000_00A5, 8,   1,  0,  0};
    vecs[1] = '{64'h0A5,                9,  0,  0,  32'h0000_00A5, 8,   0,  0,  0};
    vecs[2] = '{64'h1A5,                9,  1,  0,  32'h0000_00A5, 8,   1,  0,  0};
    vecs[3] = '{64'h3_FFFF_FFFF,        34, 0,  0,  32'hFFFF_FFFF, 32,  0,  1,  0};
    vecs[4] = '{64'h06,                 5,  0,  1,  32'h0000_0006, 4,   0,  0,  1};
    vecs[5] = '{64'h1,                  1,  0,  0,  32'h0000_0000, 0,   0,  1,  0};
    vecs[6] = '{64'h2,                  2,  0,  0,  32'h0000_0000, 1,   1,  0,  0};
    vecs[7] = '{64'h0_1234_5678,        33, 0,  0,  32'h1234_5678, 32,  1,  0,  0};
    v3c     = '{64'h13C,                9,  0,  0,  32'h0000_003C, 8,   1,  0,  0};

    repeat (3) @(negedge clk);
    check("rst busy",  32'(word_busy),  32'd0);
    check("rst valid", 32'(word_valid), 32'd0);
    check("rst data",  data_out,        32'd0);
    check("rst bcnt",  32'(bit_count),  32'd0);
    check("rst flags", {28'd0, parity_ok, len_err, frame_err, tout_err}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Both lines low from idle is a silent stop
    start = valid_cnt;
    send_stop();
    repeat (10) @(negedge clk);
    check("idle stop silent", 32'(valid_cnt - start), 32'd0);
    check("idle stop busy",   32'(word_busy), 32'd0);

    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // Second line drops while a bit is still low
    start = valid_cnt;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    sl0 = 1'b0;
    repeat (8) @(negedge clk);
    sl1 = 1'b0;
    repeat (8) @(negedge clk);
    sl0 = 1'b1;
    sl1 = 1'b1;
    wait_valid(start, 40, "frame");
    repeat (8) @(negedge clk);
    check_word("frame", 32'h3, 2, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a word discards it
    start = valid_cnt;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("pre-rst busy", 32'(word_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-rst busy", 32'(word_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst no valid", 32'(valid_cnt - start), 32'd0);
    // Counters clear with reset, so only the words after it count
    exp_good = 0;
    exp_err  = 0;
    run_vec(v3c, "after rst");

    check("single pulse", 32'(dbl_cnt), 32'd0);
`ifdef SL_RX_STATS_EN
    check("good_cnt", 32'(good_cnt), 32'(exp_good));
    check("err_cnt",  32'(err_cnt),  32'(exp_err));
`else
    check("good_cnt", 32'(good_cnt), 32'd0);
    check("err_cnt",  32'(err_cnt),  32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
